// File: rtl/time_pkg.sv
// Shared types and constants for the BCD time counter: FSM states, field selects, digit limits.
package time_pkg;

  typedef enum logic [1:0] {
    StStop    = 2'd0,
    StRun     = 2'd1,
    StExpired = 2'd2
  } state_e;

  localparam logic [1:0] SelMin  = 2'd0;
  localparam logic [1:0] SelSec  = 2'd1;
  localparam logic [1:0] SelHour = 2'd2;
  localparam logic [1:0] SelNone = 2'd3;

  localparam int unsigned SecMod  = 60;
  localparam logic [3:0]  OnesMax = 4'd9;

  function automatic logic [3:0] max_tens(input int unsigned modulus);
    return 4'((modulus - 1) / 10);
  endfunction

  function automatic logic [3:0] max_ones(input int unsigned modulus);
    return 4'((modulus - 1) % 10);
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Two-digit BCD field counting modulo MOD; carry/borrow flag a step that wraps the field.
module bcd_digit_counter
  import time_pkg::*;
#(
  parameter int unsigned MOD = 60
) (
  input  logic       i_clk,
  input  logic       i_en,
  input  logic       i_dir,
  input  logic       i_clr,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic       o_carry,
  output logic       o_borrow
);

  localparam logic [3:0] TensTop = max_tens(MOD);
  localparam logic [3:0] OnesTop = max_ones(MOD);

  logic [3:0] r_tens, r_ones;
  logic [3:0] w_tens, w_ones;
  logic       w_at_max, w_at_zero;

  assign w_at_max  = (r_tens == TensTop) && (r_ones == OnesTop);
  assign w_at_zero = (r_tens == 4'd0) && (r_ones == 4'd0);

  always_comb begin
    w_tens = r_tens;
    w_ones = r_ones;
    if (!i_dir) begin
      if (w_at_max) begin
        w_tens = 4'd0;
        w_ones = 4'd0;
      end else if (r_ones == OnesMax) begin
        w_ones = 4'd0;
        w_tens = r_tens + 4'd1;
      end else begin
        w_ones = r_ones + 4'd1;
      end
    end else begin
      if (w_at_zero) begin
        w_tens = TensTop;
        w_ones = OnesTop;
      end else if (r_ones == 4'd0) begin
        w_ones = OnesMax;
        w_tens = r_tens - 4'd1;
      end else begin
        w_ones = r_ones - 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else if (i_en) begin
      r_tens <= w_tens;
      r_ones <= w_ones;
    end
  end

  assign o_tens   = r_tens;
  assign o_ones   = r_ones;
  assign o_carry  = i_en & ~i_dir & w_at_max;
  assign o_borrow = i_en & i_dir & w_at_zero;

endmodule

// File: rtl/bcd_time_counter.sv
// Stopwatch/timer: chained BCD fields with run/stop/expired FSM, field adjust and lap freeze.
module bcd_time_counter
  import time_pkg::*;
#(
  parameter int unsigned HOURS_EN = 0,
  parameter int unsigned HOUR_MOD = 24,
  parameter int unsigned MIN_MOD  = (HOURS_EN != 0) ? 60 : 100
) (
  input  logic       M_CLK,
  input  logic       RESET_N,
  input  logic       TICK,
  input  logic       ADJ_TICK,
  input  logic       ADJ,
  input  logic [1:0] SEL,
  input  logic       DIR,
  input  logic       PAUSE_P,
  input  logic       CLEAR_P,
  input  logic       LAP_P,
  output logic [3:0] HT,
  output logic [3:0] HO,
  output logic [3:0] MT,
  output logic [3:0] MO,
  output logic [3:0] ST,
  output logic [3:0] SO,
  output logic       RUNNING,
  output logic       LAP_ACTIVE,
  output logic       WRAP,
  output logic       ZERO,
  output logic       ADJ_BLINK
);

  state_e      r_state, w_state_next;
  logic        r_lap, r_wrap, r_blink;
  logic [23:0] r_disp, w_live;
  logic [3:0]  w_ht, w_ho, w_mt, w_mo, w_st, w_so;
  logic        w_clr, w_tick_ok, w_run_step, w_expire, w_adj_step, w_zero, w_at_one;
  logic        w_adj_sec, w_adj_min, w_adj_hour;
  logic        w_sec_en, w_min_en, w_hour_en, w_top_roll;
  logic        w_sec_carry, w_sec_borrow, w_min_carry, w_min_borrow, w_hr_carry, w_hr_borrow;

  assign w_live   = {w_ht, w_ho, w_mt, w_mo, w_st, w_so};
  assign w_zero   = (w_live == 24'h0);
  assign w_at_one = (w_live == 24'h000001);
  assign w_clr    = ~RESET_N | CLEAR_P;

  // A down tick never underflows in RUN: it lands on zero (or is absorbed at zero) and expires.
  assign w_tick_ok  = (r_state == StRun) & ~ADJ & TICK & ~CLEAR_P;
  assign w_run_step = w_tick_ok & ~(DIR & w_zero);
  assign w_expire   = w_tick_ok & DIR & (w_zero | w_at_one);
  assign w_adj_step = ADJ & ADJ_TICK & ~CLEAR_P;

  always_comb begin
    w_adj_sec  = 1'b0;
    w_adj_min  = 1'b0;
    w_adj_hour = 1'b0;
    if (w_adj_step) begin
      unique case (SEL)
        SelSec:  w_adj_sec  = 1'b1;
        SelMin:  w_adj_min  = 1'b1;
        SelHour: w_adj_hour = (HOURS_EN != 0);
        SelNone: ;
      endcase
    end
  end

  assign w_sec_en   = w_run_step | w_adj_sec;
  assign w_min_en   = (w_run_step & (w_sec_carry | w_sec_borrow)) | w_adj_min;
  assign w_hour_en  = (w_run_step & (w_min_carry | w_min_borrow)) | w_adj_hour;
  assign w_top_roll = (HOURS_EN != 0) ? (w_hr_carry | w_hr_borrow) : (w_min_carry | w_min_borrow);

  bcd_digit_counter #(.MOD(SecMod)) u_sec (
    .i_clk   (M_CLK),
    .i_en    (w_sec_en),
    .i_dir   (DIR),
    .i_clr   (w_clr),
    .o_tens  (w_st),
    .o_ones  (w_so),
    .o_carry (w_sec_carry),
    .o_borrow(w_sec_borrow)
  );

  bcd_digit_counter #(.MOD(MIN_MOD)) u_min (
    .i_clk   (M_CLK),
    .i_en    (w_min_en),
    .i_dir   (DIR),
    .i_clr   (w_clr),
    .o_tens  (w_mt),
    .o_ones  (w_mo),
    .o_carry (w_min_carry),
    .o_borrow(w_min_borrow)
  );

  // Held in clear when hours are disabled so the field reads as a constant zero.
  bcd_digit_counter #(.MOD(HOUR_MOD)) u_hour (
    .i_clk   (M_CLK),
    .i_en    (w_hour_en),
    .i_dir   (DIR),
    .i_clr   (w_clr | (HOURS_EN == 0)),
    .o_tens  (w_ht),
    .o_ones  (w_ho),
    .o_carry (w_hr_carry),
    .o_borrow(w_hr_borrow)
  );

  always_ff @(posedge M_CLK) begin
    if (!RESET_N) r_state <= StStop;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StStop:    if (PAUSE_P) w_state_next = StRun;
      StRun: begin
        if (PAUSE_P)       w_state_next = StStop;
        else if (w_expire) w_state_next = StExpired;
      end
      StExpired: if (CLEAR_P || !DIR) w_state_next = StStop;
      default:   w_state_next = StStop;
    endcase
  end

  always_ff @(posedge M_CLK) begin
    if (!RESET_N) begin
      r_lap   <= 1'b0;
      r_disp  <= 24'h0;
      r_wrap  <= 1'b0;
      r_blink <= 1'b1;
    end else begin
      r_wrap <= w_run_step & w_top_roll;
      if (!ADJ)          r_blink <= 1'b1;
      else if (ADJ_TICK) r_blink <= ~r_blink;
      if (CLEAR_P) begin
        r_lap <= 1'b0;
      end else if (LAP_P) begin
        r_lap <= ~r_lap;
        if (!r_lap) r_disp <= w_live;
      end
    end
  end

  assign {HT, HO, MT, MO, ST, SO} = r_lap ? r_disp : w_live;
  assign RUNNING    = (r_state == StRun);
  assign LAP_ACTIVE = r_lap;
  assign WRAP       = r_wrap;
  assign ZERO       = w_zero;
  assign ADJ_BLINK  = r_blink;

endmodule

// File: doc/bcd_time_counter.md
BCD_TIME_COUNTER -- requirements
Module: bcd_time_counter

Interface
REQ-001 SHALL have parameter HOURS_EN, default 0: 1 enables the hour field (HT/HO); 0 ties HT/HO to 0 and the minute field becomes the most significant.
REQ-002 SHALL have parameter HOUR_MOD, default 24: hour field modulus, legal range 2..99.
REQ-003 SHALL have parameter MIN_MOD, default 100 when HOURS_EN=0 and 60 otherwise: minute field modulus, legal range 2..100.
REQ-004 SHALL have port M_CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port RESET_N, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port TICK, input, 1 bit: one-cycle run-rate count enable (one time unit).
REQ-007 SHALL have port ADJ_TICK, input, 1 bit: one-cycle adjust-rate enable.
REQ-008 SHALL have port ADJ, input, 1 bit: adjust mode level.
REQ-009 SHALL have port SEL, input, 2 bits: adjust field select; 0 = minutes, 1 = seconds, 2 = hours, 3 = none.
REQ-010 SHALL have port DIR, input, 1 bit: count direction; 0 = up, 1 = down.
REQ-011 SHALL have port PAUSE_P, input, 1 bit: one-cycle run/pause toggle request, already debounced.
REQ-012 SHALL have port CLEAR_P, input, 1 bit: one-cycle clear request.
REQ-013 SHALL have port LAP_P, input, 1 bit: one-cycle lap freeze/release request.
REQ-014 SHALL have ports HT, HO, MT, MO, ST, SO, output, 4 bits each: displayed BCD digits (tens/ones of hours, minutes, seconds).
REQ-015 SHALL have port RUNNING, output, 1 bit: FSM is in RUN.
REQ-016 SHALL have port LAP_ACTIVE, output, 1 bit: display is frozen.
REQ-017 SHALL have port WRAP, output, 1 bit: one-cycle pulse when the top field rolls over (up) or under (down).
REQ-018 SHALL have port ZERO, output, 1 bit: level, live count is all zero.
REQ-019 SHALL have port ADJ_BLINK, output, 1 bit: toggles on each ADJ_TICK while ADJ=1 and is held at 1 while ADJ=0.

Function
REQ-020 SHALL implement FSM states STOP, RUN and EXPIRED.
REQ-021 SHALL transition STOP->RUN and RUN->STOP on PAUSE_P.
REQ-022 SHALL transition RUN->EXPIRED when DIR=1 and the count reaches all zero.
REQ-023 SHALL transition EXPIRED->STOP on CLEAR_P or on DIR=0; PAUSE_P SHALL be ignored in EXPIRED.
REQ-024 SHALL apply event priority per cycle CLEAR_P > adjust > run tick; lower-priority events in the same cycle are discarded.
REQ-025 On CLEAR_P, SHALL zero all live digits and release lap on the next edge, while the FSM state is retained except EXPIRED->STOP.
REQ-026 In RUN with ADJ=0 and TICK=1, SHALL step the live count by ±1 second with full BCD carry/borrow: SO mod 10, ST mod 6, minutes mod MIN_MOD, hours mod HOUR_MOD.
REQ-027 On rollover from the maximum value up, or underflow from zero down outside RUN-to-EXPIRED handling, SHALL wrap and pulse WRAP for exactly one cycle.
REQ-028 In down-count, SHALL NOT underflow: when the count reaches 0, the FSM enters EXPIRED, the count holds at 0 and WRAP is not asserted.
REQ-029 When ADJ=1, SHALL suspend run ticks regardless of state.
REQ-030 When ADJ=1 and ADJ_TICK=1, SHALL step only the SEL field by ±1 per DIR, wrapping within that field with no carry and no WRAP pulse.
REQ-031 SHALL ignore SEL=2 when HOURS_EN=0, and SHALL ignore SEL=3.
REQ-032 On LAP_P with LAP_ACTIVE=0, SHALL copy the live count to the display register and set LAP_ACTIVE, with counting continuing underneath.
REQ-033 On LAP_P with LAP_ACTIVE=1, SHALL clear LAP_ACTIVE.
REQ-034 SHALL drive the outputs from the live count when LAP_ACTIVE=0 and from the display register when LAP_ACTIVE=1.
REQ-035 SHALL register all outputs with 1-cycle latency from the causing event.
REQ-036 SHALL keep digits always valid BCD within their modulus.

Reset
REQ-037 While RESET_N=0 at a clock edge, SHALL force: all digits 0, FSM=STOP, LAP_ACTIVE=0, WRAP=0, RUNNING=0, ADJ_BLINK=1, ZERO=1.
REQ-038 A reset asserted mid-count or mid-lap SHALL abandon that operation, with no pending events surviving reset.

Structure
REQ-039 SHALL place the state enum (STOP/RUN/EXPIRED), SEL encodings and BCD digit limits in shared package time_pkg.
REQ-040 SHALL use sub-module bcd_digit_counter (parameter MOD; inputs en, dir, clr; outputs digit pair, carry, borrow), instantiated once per field and chained.

Verification
REQ-041 Bench SHALL cover up-count wrap: HOURS_EN=0, count at 99:59, RUN, TICK -> 00:00, WRAP high for 1 cycle.
REQ-042 Bench SHALL cover down-count expiry: preload 00:02 via adjust, DIR=1, RUN, 2 TICKs -> 00:00, ZERO=1, RUNNING=0; third TICK -> count unchanged.
REQ-043 Bench SHALL cover adjust without carry: ADJ=1, SEL=1, seconds=59, ADJ_TICK -> seconds 00, minutes unchanged, no WRAP.
REQ-044 Bench SHALL cover lap: count 01:10, LAP_P, then 5 TICKs -> outputs show 01:10, live count 01:15; second LAP_P -> outputs 01:15.
REQ-045 Bench SHALL cover simultaneous events: CLEAR_P with TICK and ADJ_TICK in the same cycle -> 00:00, no WRAP, FSM unchanged.
REQ-046 Bench SHALL cover hours: HOURS_EN=1, count 23:59:59, TICK -> 00:00:00, WRAP pulse; RESET_N low mid-lap -> all reset values next edge.
